// File: rtl/trace_capture_pkg.sv
// trace_capture_pkg: shared types and constants for the retired-instruction trace.
//   Entry kind encodings (TRACE_KIND_*), the data width, and the packed entry
//   layout. TRACE_TIMESTAMP_EN adds a 32-bit stamp field (162-bit entry, else 130).
package trace_capture_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    TRACE_KIND_ALU   = 2'd0,
    TRACE_KIND_LOAD  = 2'd1,
    TRACE_KIND_STORE = 2'd2,
    TRACE_KIND_HALT  = 2'd3
  } trace_kind_e;

  typedef struct packed {
`ifdef TRACE_TIMESTAMP_EN
    logic [DATA_W-1:0] stamp;
`endif
    trace_kind_e       kind;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] data;
  } trace_entry_t;

  localparam int unsigned ENTRY_W = $bits(trace_entry_t);

endpackage

// File: rtl/trace_capture_if.sv
// trace_capture_if: core-observation inputs, drain handshake and status outputs.
//   master: core/consumer side (drives core signals and rd_ready).
//   slave : trace_capture side (drives rd_* fields, count and counters).
//   rd_stamp exists only when TRACE_TIMESTAMP_EN is defined.
interface trace_capture_if #(parameter int unsigned DEPTH = 16) ();
  import trace_capture_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              enable;
  logic [DATA_W-1:0] pc;
  logic [DATA_W-1:0] instr;
  logic [DATA_W-1:0] alu_result;
  logic              mem_write;
  logic              mem_read;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_pc;
  logic [DATA_W-1:0] rd_instr;
  logic [DATA_W-1:0] rd_alu;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_kind;
  logic [CNT_W-1:0]  count;
  logic [31:0]       retired;
  logic [15:0]       dropped;
  logic              overflow;
  logic              halted;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]       rd_stamp;
`endif

  modport master (
    output enable, pc, instr, alu_result, mem_write, mem_read, mem_wdata,
           mem_rdata, rd_ready,
    input  rd_valid, rd_pc, rd_instr, rd_alu, rd_data, rd_kind, count,
           retired, dropped, overflow, halted
`ifdef TRACE_TIMESTAMP_EN
           , rd_stamp
`endif
  );

  modport slave (
    input  enable, pc, instr, alu_result, mem_write, mem_read, mem_wdata,
           mem_rdata, rd_ready,
    output rd_valid, rd_pc, rd_instr, rd_alu, rd_data, rd_kind, count,
           retired, dropped, overflow, halted
`ifdef TRACE_TIMESTAMP_EN
           , rd_stamp
`endif
  );

endinterface

// File: rtl/trace_capture_fifo.sv
// trace_fifo: generic synchronous FIFO, power-of-two DEPTH.
//   clock/reset     : clock, async active-high reset
//   push_i/push_data_i : write request and data
//   pop_i           : read request (ignored when empty)
//   pop_data_o      : head entry, read combinationally from registered storage
//   full_o/empty_o/count_o : occupancy
//   A push while full is accepted when a pop happens in the same cycle.
module trace_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o     = (count_q == CNT_W'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign count_o    = count_q;
  assign pop_data_o = mem_q[rd_ptr_q];

  // Next pointers/count; pointers wrap naturally at the power-of-two depth
  always_comb begin
    pop_ok   = pop_i && !empty_o;
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CNT_W'(1);
    else if (pop_ok && !push_ok) count_d = count_q - CNT_W'(1);
  end

  // Storage and pointer registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/trace_capture.sv
// trace_capture: records one entry per retired MIPS instruction into a FIFO,
//   counts retired/dropped entries and detects a halt (PC self-loop).
//   clock, reset : clock, async active-high reset
//   tif (slave)  : core observation inputs, drain handshake, status outputs
//   Parameters   : DEPTH (entries), HALT_REPEAT (repeat cycles), MEM_ONLY.
//   Optional     : TRACE_TIMESTAMP_EN adds a cycle counter and rd_stamp.
module trace_capture
  import trace_capture_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned HALT_REPEAT = 3,
  parameter int unsigned MEM_ONLY    = 0
) (
  input  logic            clock,
  input  logic            reset,
  trace_capture_if.slave  tif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned REP_W = $clog2(HALT_REPEAT);

  logic [31:0]       retired_q,  retired_d;
  logic [15:0]       dropped_q,  dropped_d;
  logic              overflow_q, overflow_d;
  logic              halted_q,   halted_d;
  logic [DATA_W-1:0] prev_pc_q,  prev_pc_d;
  logic              prev_vld_q, prev_vld_d;
  logic [REP_W-1:0]  rep_q,      rep_d;
`ifdef TRACE_TIMESTAMP_EN
  logic [31:0]       stamp_q,    stamp_d;
`endif

  logic              active;
  logic              capture;
  logic              pc_repeat;
  logic              halt_hit;
  logic              push;
  logic              pop;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  trace_entry_t      push_entry;
  trace_entry_t      head_entry;
  logic [ENTRY_W-1:0] head_bits;

  trace_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clock       (clock),
    .reset       (reset),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .pop_data_o  (head_bits),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign head_entry   = trace_entry_t'(head_bits);
  assign pop          = !fifo_empty && tif.rd_ready;
  assign tif.rd_valid = !fifo_empty;
  assign tif.rd_pc    = head_entry.pc;
  assign tif.rd_instr = head_entry.instr;
  assign tif.rd_alu   = head_entry.alu;
  assign tif.rd_data  = head_entry.data;
  assign tif.rd_kind  = head_entry.kind;
  assign tif.count    = fifo_count;
  assign tif.retired  = retired_q;
  assign tif.dropped  = dropped_q;
  assign tif.overflow = overflow_q;
  assign tif.halted   = halted_q;
`ifdef TRACE_TIMESTAMP_EN
  assign tif.rd_stamp = head_entry.stamp;
`endif

  // Capture qualification, halt detection and entry formation.
  // On the halting edge the halt marker takes the single push slot in place
  // of the ordinary entry for that cycle; retired still counts the cycle.
  always_comb begin
    active    = tif.enable && !halted_q;
    capture   = active && ((MEM_ONLY == 0) || tif.mem_write || tif.mem_read);
    pc_repeat = prev_vld_q && (tif.pc == prev_pc_q);
    halt_hit  = active && pc_repeat && (rep_q == REP_W'(HALT_REPEAT - 2));
    push      = capture || halt_hit;
    drop      = push && fifo_full && !pop;

    push_entry       = '0;
    push_entry.pc    = tif.pc;
    push_entry.instr = tif.instr;
    push_entry.alu   = tif.alu_result;
`ifdef TRACE_TIMESTAMP_EN
    push_entry.stamp = stamp_q;
`endif
    if (halt_hit) begin
      push_entry.kind = TRACE_KIND_HALT;
      push_entry.alu  = '0;
    end else if (tif.mem_write) begin
      push_entry.kind = TRACE_KIND_STORE;
      push_entry.data = tif.mem_wdata;
    end else if (tif.mem_read) begin
      push_entry.kind = TRACE_KIND_LOAD;
      push_entry.data = tif.mem_rdata;
    end else begin
      push_entry.kind = TRACE_KIND_ALU;
    end

    retired_d  = retired_q;
    dropped_d  = dropped_q;
    overflow_d = overflow_q;
    halted_d   = halted_q;
    prev_pc_d  = prev_pc_q;
    prev_vld_d = prev_vld_q;
    rep_d      = rep_q;
`ifdef TRACE_TIMESTAMP_EN
    stamp_d    = halted_q ? stamp_q : stamp_q + 32'd1;
`endif

    if (capture) retired_d = retired_q + 32'd1;
    if (drop) begin
      overflow_d = 1'b1;
      if (dropped_q != 16'hFFFF) dropped_d = dropped_q + 16'd1;
    end
    if (halt_hit) halted_d = 1'b1;

    if (active) begin
      prev_pc_d  = tif.pc;
      prev_vld_d = 1'b1;
      rep_d      = pc_repeat ? REP_W'(rep_q + REP_W'(1)) : '0;
    end else if (!tif.enable) begin
      rep_d = '0;
    end
  end

  // Counter, flag and halt-detector registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired_q  <= '0;
      dropped_q  <= '0;
      overflow_q <= 1'b0;
      halted_q   <= 1'b0;
      prev_pc_q  <= '0;
      prev_vld_q <= 1'b0;
      rep_q      <= '0;
`ifdef TRACE_TIMESTAMP_EN
      stamp_q    <= '0;
`endif
    end else begin
      retired_q  <= retired_d;
      dropped_q  <= dropped_d;
      overflow_q <= overflow_d;
      halted_q   <= halted_d;
      prev_pc_q  <= prev_pc_d;
      prev_vld_q <= prev_vld_d;
      rep_q      <= rep_d;
`ifdef TRACE_TIMESTAMP_EN
      stamp_q    <= stamp_d;
`endif
    end
  end

endmodule

// File: doc/trace_capture.md
Name: trace_capture

Overview:
- Downstream observer of the single-cycle MIPS core, fed by its PCOut, instruction, ALUResultOut, MemOut, MemWrite and MemRead signals.
- Records one trace entry per retired instruction into a circular buffer, which the bench or a debug port drains over a valid/ready handshake.
- Detects a program halt (a self-loop at a fixed PC), so simulations end on completion rather than on a fixed time limit.
- Keeps a retired-instruction counter and a dropped-entry counter.

Parameters:
- DEPTH, 16: buffer entries; power of two, minimum 2.
- HALT_REPEAT, 3: consecutive cycles with an unchanged PC that declare a halt; minimum 2.
- MEM_ONLY, 0: 1 captures only cycles with mem_write or mem_read set; 0 captures every cycle.

Ports:
- clock  in  1  Core clock.
- reset  in  1  Asynchronous, active-high reset.
- enable  in  1  Capture enable; when low, nothing is pushed and counters hold.
- pc  in  32  Core PCOut.
- instr  in  32  Core instruction.
- alu_result  in  32  Core ALUResultOut; this is the memory address on load/store cycles.
- mem_write  in  1  Core MemWrite.
- mem_read  in  1  Core MemRead.
- mem_wdata  in  32  Data-memory write data.
- mem_rdata  in  32  Core MemOut.
- rd_valid  out  1  Head entry is available.
- rd_ready  in  1  Consumer accepts the head entry.
- rd_pc, rd_instr, rd_alu, rd_data  out  32 each  Head entry fields. rd_data holds mem_wdata on a store, mem_rdata on a load, 0 otherwise.
- rd_kind  out  2  Entry kind: 0 = ALU, 1 = load, 2 = store, 3 = halt marker.
- count  out  log2(DEPTH)+1  Number of occupied entries.
- retired  out  32  Captured-cycle counter.
- dropped  out  16  Entries lost to overflow; saturates at 0xFFFF.
- overflow  out  1  Sticky; set on the first drop.
- halted  out  1  Sticky halt flag.

Behaviour:
- Reset: all outputs 0, pointers cleared, halt-detector state cleared. Reset applies immediately, including mid-transfer; an entry being presented is discarded.
- Capture condition, sampled on the rising clock edge: enable && !halted && (!MEM_ONLY || mem_write || mem_read).
- Kind priority: mem_write over mem_read (both set is a core bug; record it as a store).
- retired increments on every capture condition, whether or not the entry is dropped. It wraps modulo 2^32.
- Push accepted when count < DEPTH, or when count == DEPTH and a pop happens in the same cycle (simultaneous push and pop when full succeeds).
- A rejected push increments dropped and sets overflow. The buffer contents are unchanged.
- Pop occurs when rd_valid && rd_ready. rd_valid = (count != 0). The rd_* fields show the head combinationally from registered storage and stay stable while rd_valid && !rd_ready.
- Pointers wrap modulo DEPTH. Simultaneous push and pop leaves count unchanged.
- Latency: an entry captured at edge N gives rd_valid at N+1 if the buffer was empty.
- Halt detector, active while enable && !halted:
  - The repeat counter increments when pc equals the pc registered on the previous cycle, and resets to 0 otherwise.
  - When the counter reaches HALT_REPEAT-1, halted is set on that edge.
  - A single kind-3 entry is pushed with rd_pc = the loop PC. It goes through the normal overflow rule. MEM_ONLY does not suppress it.
- After the halt, captures and counters freeze; draining continues. halted clears only on reset.
- Edge cases:
  - The first cycle after reset has no previous PC, so no repeat is counted.
  - enable low clears the repeat counter.

Optional Feature:
- Macro TRACE_TIMESTAMP_EN.
- When defined:
  - A free-running 32-bit cycle counter is added. It increments every cycle after reset, independent of enable, and stops when halted.
  - Each entry stores the counter value at capture, presented on an extra output rd_stamp, 32 bits.
  - The halt entry carries the halt cycle.
- When undefined: no counter, no rd_stamp port, no storage for it.

Decomposition:
- Shared defines header: the TRACE_KIND_ALU, TRACE_KIND_LOAD, TRACE_KIND_STORE and TRACE_KIND_HALT encodings, the 32-bit data-width constant, and the entry-width macro (130 bits, or 162 with TRACE_TIMESTAMP_EN).
- One sub-module, trace_fifo: a generic synchronous FIFO parameterised on width and depth, with push, pop, full, empty and count. Using the same clock and asynchronous reset, it accepts a push when full if a pop occurs in the same cycle.
- trace_capture contains the capture logic, kind encoding, counters and halt detector.

Test Plan:
- Three ALU cycles (pc 0x00, 0x04, 0x08), rd_ready held 1 -> three kind-0 entries in order, each one cycle after capture; retired = 3; count returns to 0.
- Store at pc 0x0C with alu_result 0x10 and mem_wdata 0xDEADBEEF, then a load at pc 0x10 with mem_rdata 0xDEADBEEF -> entries of kind 2 and kind 1, each with rd_alu = 0x10 and rd_data = 0xDEADBEEF.
- DEPTH = 4, rd_ready 0, six captures -> count = 4, dropped = 2, overflow = 1. Then one cycle with a capture and rd_ready = 1 -> count stays 4 and dropped stays 2.
- pc held at 0x24 for 3 cycles with HALT_REPEAT = 3 -> halted = 1 on the third edge, a kind-3 entry with rd_pc = 0x24 is pushed, and retired freezes afterwards.
- Reset asserted asynchronously mid-clock while rd_valid = 1 and count = 2 -> rd_valid, count, retired and halted read 0 before the next edge.
- MEM_ONLY = 1, sequence ALU, ALU, store -> only the store entry is buffered; retired = 1.
